// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiplier and restoring divider.
// Optional MULDIV_FASTPATH_EN: divide-by-zero, signed overflow and zero-operand multiply skip CALC.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_func3;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg, r_rem_neg;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_b_zero;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic                w_fast;
  logic [2*XLEN-1:0]   w_acc_init, w_fast_acc;
  logic [XLEN:0]       w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]   w_step, w_prod;
  logic [XLEN-1:0]     w_quot, w_rem, w_fix;

  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_is_div   = func3[2];
  // MUL/MULH/DIV/REM treat both operands as signed; MULHSU only op_a.
  assign w_a_signed = w_is_div ? ~func3[0] : (func3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~func3[0] : ~func3[1];
  assign w_sa       = w_a_signed & op_a[XLEN-1];
  assign w_sb       = w_b_signed & op_b[XLEN-1];
  assign w_mag_a    = w_sa ? -op_a : op_a;
  assign w_mag_b    = w_sb ? -op_b : op_b;
  assign w_b_zero   = (op_b == '0);
  assign w_acc_init = w_is_div ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};

`ifdef MULDIV_FASTPATH_EN
  logic w_ovf;
  assign w_ovf = w_is_div && !func3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  always_comb begin
    w_fast     = 1'b0;
    w_fast_acc = '0;
    if (w_is_div) begin
      if (w_b_zero) begin
        w_fast     = 1'b1;
        w_fast_acc = {w_mag_a, {XLEN{1'b1}}};
      end else if (w_ovf) begin
        w_fast     = 1'b1;
        w_fast_acc = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
      end
    end else if ((op_a == '0) || w_b_zero) begin
      w_fast = 1'b1;
    end
  end
`else
  assign w_fast     = 1'b0;
  assign w_fast_acc = '0;
`endif

  // One iteration: multiply adds into the upper half then shifts right;
  // divide shifts {rem,quot} left and keeps the trial subtraction if it did not borrow.
  always_comb begin
    w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, r_opnd};
    if (!r_func3[2])
      w_step = {w_sum, r_acc[XLEN-1:1]};
    else if (!w_diff[XLEN])
      w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    else
      w_step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  end

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_rem_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    case (r_func3)
      3'b000:                 w_fix = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = w_quot;
      default:                w_fix = w_rem;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_fast ? S_FIXUP : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(XLEN-1)) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == S_CALC) || (w_next == S_FIXUP);
      done    <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func3   <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_cnt     <= '0;
      result    <= '0;
    end else begin
      if (w_accept) begin
        r_func3   <= func3;
        r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
        r_acc     <= w_fast ? w_fast_acc : w_acc_init;
        // A zero divisor keeps the all-ones quotient unsigned.
        r_neg     <= w_is_div ? ((w_sa ^ w_sb) & ~w_b_zero) : (w_sa ^ w_sb);
        r_rem_neg <= w_sa;
        r_cnt     <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_FIXUP) && !flush) result <= w_fix;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin pu = {32'h0, a} * {32'h0, b}; return pu[31:0]; end
      3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
      3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (f[2] && (b == 0)) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (!f[2] && (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  // Presents one request at a negedge; returns just after the accepting edge with junk on the inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; func3 = f; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  // Counts cycles to the done pulse (0 if it never comes within the budget).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_after_accept", {31'b0, busy}, 32'd1);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    issue(f, a, b);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat(f, a, b));
    check(tag, result, exp);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t dir[11] = '{
    '{"mul_7_m3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{"mulh_7_m3",    3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
    '{"mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{"mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    '{"div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{"rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{"divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14},
    '{"remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2},
    '{"divu_5_0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{"rem_5_0",      3'd6, 32'd5,         32'd0,         32'd5},
    '{"div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}
  };

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    bit          seen;
    logic [31:0] a, b, keep;
    logic [2:0]  f;

    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (dir[i]) run_op(dir[i].tag, dir[i].f, dir[i].a, dir[i].b, dir[i].exp);

    // A start pulse with new operands mid-CALC must not disturb the running MUL.
    issue(3'd0, 32'd12345, 32'd678);
    repeat (5) @(negedge clk);
    start = 1'b1; func3 = 3'd5; op_a = $urandom; op_b = $urandom | 32'h1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check("ignored_start_lat", 5 + lat, 34);
    check("ignored_start_result", result, 32'd8369910);
    @(negedge clk);

    // Flush in CALC: back to IDLE, no done pulse, previous result retained.
    keep = result;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("flush_no_done", {31'b0, seen}, 32'd0);
    check("flush_result_kept", result, keep);

    // Asynchronous reset at cycle 10 of a MUL clears everything immediately.
    issue(3'd0, 32'h0001_0003, 32'h0000_0105);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_reset", 3'd0, 32'h0001_0003, 32'h0000_0105, model(3'd0, 32'h0001_0003, 32'h0000_0105));

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), f, a, b, model(f, a, b));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide operations, selected when the ALU decode sees R-type arithmetic with func7 = 7'b0000001.
- Accepts one operation from the execute stage and iterates a shift-add multiplier or a restoring divider over XLEN cycles.
- Applies sign fixup, then returns the result with a one-cycle done pulse.
- Raises busy so the hazard logic holds the pipeline.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a new operation; sampled only in IDLE.
func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  in  XLEN  rs1 value (multiplicand / dividend).
op_b  in  XLEN  rs2 value (multiplier / divisor).
flush  in  1  abort the current operation (branch/jump squash).
busy  out  1  registered; high in CALC and FIXUP.
done  out  1  registered; single-cycle pulse, high in DONE only.
result  out  XLEN  registered; valid when done=1, held until next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers 0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1, flush=0 (edge t):
  - Latch func3.
  - Latch operand magnitudes and the result sign. Signed operands are MUL/MULH/DIV/REM: both; MULHSU: op_a only.
  - Counter=0; go to CALC; busy=1 from t+1.
- CALC, multiply:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*XLEN accumulator, then shift right 1.
- CALC, divide (restoring):
  - Each cycle, shift {remainder,quotient} left 1, trial-subtract the divisor, keep the result if non-negative and set quotient LSB.
- CALC leaves after exactly XLEN cycles (counter==XLEN-1) -> FIXUP.
- FIXUP:
  - Negate the magnitude result if the sign is set. Remainder sign follows the dividend.
  - Select the low half (MUL), high half (MULH*), quotient (DIV*) or remainder (REM*) into result.
  - Go to DONE.
- DONE: done=1, busy=0; go to IDLE next cycle.
- Latency: start sampled at edge t -> done high in cycle t+XLEN+2 (34 for XLEN=32). Back-to-back start is accepted in the cycle after DONE.
- Arithmetic rules (RISC-V M):
  - Divide by zero: quotient = all ones; remainder = op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - All arithmetic wraps modulo 2^XLEN.
- start outside IDLE: ignored, with no effect on state or operands.
- flush in any state other than IDLE: next state IDLE, busy=0, done never asserted, result unchanged. flush has priority over start in IDLE (request not accepted).
- Operands need not stay stable after acceptance.

Optional Feature:
MULDIV_FASTPATH_EN
- Defined: when the operation is accepted, these cases skip CALC and go straight to FIXUP, so done arrives at t+2:
  - divide by zero;
  - signed overflow;
  - multiply with op_a==0 or op_b==0.
  Results are identical to the iterative path.
- Undefined: every operation takes the full XLEN+2 latency.

Test Plan:
- Reset mid-CALC: assert rst at cycle 10 of a MUL -> busy=0, done=0, result=0 immediately; the next start runs normally.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), then MULH with the same operands -> done at t+34; results 0xFFFFFFEB and 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - With MULDIV_FASTPATH_EN: done at t+2.
  - Without it: done at t+34.
- Ignored start and flush:
  - Pulse start with new operands during CALC -> result is unaffected.
  - flush at cycle 5 of CALC -> IDLE next cycle, no done pulse, previous result retained.
